vsn_channel_delay: RTL and testbench

- Per-link channel model between a DAC-side AXI4-Stream and the VSN cable plant port it drives.
- Each accepted I/Q sample is delayed by a programmable integer number of samples (cable propagation) and scaled by a signed fixed-point gain (cable loss or inversion).
- Emits exactly one output sample per accepted input sample.
- One instance per DAC lane, placed directly upstream of vsn_cable_plant_1.

---
 rtl/vsn_pkg.sv | 56 +++++
 rtl/vsn_sdp_ram.sv | 42 ++++
 rtl/vsn_channel_delay.sv | 206 ++++++++++++++++++++
 tb/tb_vsn_channel_delay.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vsn_pkg
//  Description : Shared types, constants and the Q1.14 round/saturate helper
//                used by the VSN channel delay model.
//  Revision    : 1.0 - initial release
// ============================================================================
package vsn_pkg;

    // Sample width of the I/Q container type and the widest lane the
    // round/saturate helper can return.
    localparam int VSN_SAMPLE_W = 16;
    localparam int VSN_RES_W    = 32;

    // Gain is Q1.14: 16384 represents 1.0.
    localparam int GAIN_FRAC = 14;
    localparam int GAIN_ONE  = 16384;

    // I occupies the low half of a packed sample, Q the upper half.
    typedef struct packed {
        logic signed [VSN_SAMPLE_W-1:0] q;
        logic signed [VSN_SAMPLE_W-1:0] i;
    } vsn_iq_t;

    typedef struct packed {
        logic                        sat;
        logic signed [VSN_RES_W-1:0] val;
    } vsn_sat_t;

    // Round half up, drop the fractional bits, then clip to a signed
    // sample_w-bit range. The product is passed sign-extended to 64 bits so
    // the same helper serves any lane/gain width combination.
    function automatic vsn_sat_t vsn_sat_round(input logic signed [63:0] p,
                                               input int                 sample_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        vsn_sat_t           res;
        r  = (p + (64'sd1 <<< (GAIN_FRAC - 1))) >>> GAIN_FRAC;
        hi = (64'sd1 <<< (sample_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (sample_w - 1));
        if (r > hi) begin
            res.val = hi[VSN_RES_W-1:0];
            res.sat = 1'b1;
        end else if (r < lo) begin
            res.val = lo[VSN_RES_W-1:0];
            res.sat = 1'b1;
        end else begin
            res.val = r[VSN_RES_W-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vsn_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : vsn_sdp_ram
//  Description : Simple dual-port RAM, one write port and one registered
//                read port with read enable. Holds the delay history.
//  Revision    : 1.0 - initial release
// ============================================================================
module vsn_sdp_ram
    import vsn_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port and synchronous read port; the read register holds while
    // i_re is low so a stalled pipeline keeps its read data.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/vsn_channel_delay.sv
`default_nettype none
// ============================================================================
//  Module      : vsn_channel_delay
//  Description : Per-lane cable channel model. Delays each accepted I/Q
//                sample by a programmable number of samples and scales it by
//                a signed Q1.14 gain with rounding and saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module vsn_channel_delay
    import vsn_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 10,
    parameter int GAIN_W   = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [2*SAMPLE_W-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [2*SAMPLE_W-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    input  logic [ADDR_W-1:0]     cfg_delay,
    input  logic [GAIN_W-1:0]     cfg_gain,
    input  logic                  cfg_load,
    output logic                  sat_flag,
    input  logic                  sat_clr
);

    localparam int                c_DATA_W     = 2 * SAMPLE_W;
    localparam int                c_PROD_W     = SAMPLE_W + GAIN_W;
    localparam logic [ADDR_W-1:0] c_FILL_MAX   = '1;
    localparam logic [GAIN_W-1:0] c_GAIN_UNITY = GAIN_W'(GAIN_ONE);

    // Latched configuration and history bookkeeping
    logic [ADDR_W-1:0]   r_delay;
    logic [GAIN_W-1:0]   r_gain;
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_fill;

    // Stage 1 registers
    logic                r_s1_valid;
    logic                r_s1_last;
    logic                r_s1_prime;
    logic                r_s1_bypass;
    logic [c_DATA_W-1:0] r_s1_data;
    logic [GAIN_W-1:0]   r_s1_gain;

    // Stage 2 (output) registers
    logic                r_m_tvalid;
    logic                r_m_tlast;
    logic [c_DATA_W-1:0] r_m_tdata;
    logic                r_sat;

    logic                w_en;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_delay;
    logic [GAIN_W-1:0]   w_gain;
    logic [ADDR_W-1:0]   w_fill;
    logic [ADDR_W-1:0]   w_raddr;
    logic [c_DATA_W-1:0] w_ram_rdata;
    logic [c_DATA_W-1:0] w_x;
    logic signed [SAMPLE_W-1:0] w_x_i;
    logic signed [SAMPLE_W-1:0] w_x_q;
    logic signed [GAIN_W-1:0]   w_g;
    logic signed [c_PROD_W-1:0] w_p_i;
    logic signed [c_PROD_W-1:0] w_p_q;
    vsn_sat_t            w_res_i;
    vsn_sat_t            w_res_q;
    logic                w_load_sat;
    logic                w_unused_hi;

    // The whole pipeline moves together whenever the output slot is free.
    assign w_en     = !r_m_tvalid || m_tready;
    assign w_accept = s_tvalid && w_en;
    assign s_tready = w_en;

    // A sample arriving together with cfg_load is the first sample of the
    // new configuration, so it sees the incoming values and an empty history.
    assign w_delay = cfg_load ? cfg_delay : r_delay;
    assign w_gain  = cfg_load ? cfg_gain  : r_gain;
    assign w_fill  = cfg_load ? '0        : r_fill;
    assign w_raddr = r_wptr - w_delay;

    vsn_sdp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (c_DATA_W)
    ) u_ram (
        .clk     (aclk),
        .i_we    (w_accept),
        .i_waddr (r_wptr),
        .i_wdata (s_tdata),
        .i_re    (w_en),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_rdata)
    );

    // Configuration latch; only cfg_load changes it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_delay <= '0;
            r_gain  <= c_GAIN_UNITY;
        end else if (cfg_load) begin
            r_delay <= cfg_delay;
            r_gain  <= cfg_gain;
        end
    end

    // Write pointer advances per accepted sample; fill counts samples since
    // reset or the last cfg_load and stops at its maximum.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (cfg_load) begin
                r_fill <= w_accept ? ADDR_W'(1) : '0;
            end else if (w_accept && (r_fill != c_FILL_MAX)) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // Stage 1: capture the slot's control bits alongside the RAM read. The
    // gain travels with the sample so in-flight data keeps its old config.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_prime  <= 1'b0;
            r_s1_bypass <= 1'b0;
            r_s1_data   <= '0;
            r_s1_gain   <= c_GAIN_UNITY;
        end else if (w_en) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_last   <= s_tlast;
                r_s1_prime  <= (w_fill < w_delay);
                r_s1_bypass <= (w_delay == '0);
                r_s1_data   <= s_tdata;
                r_s1_gain   <= w_gain;
            end
        end
    end

    // Select the delayed sample: zero while priming, the captured input for
    // zero delay (avoids reading the location being written), else the RAM.
    always_comb begin
        w_x = r_s1_bypass ? r_s1_data : w_ram_rdata;
        if (r_s1_prime) begin
            w_x = '0;
        end
    end

    assign w_x_i = w_x[SAMPLE_W-1:0];
    assign w_x_q = w_x[c_DATA_W-1:SAMPLE_W];
    assign w_g   = r_s1_gain;
    assign w_p_i = c_PROD_W'(w_x_i) * c_PROD_W'(w_g);
    assign w_p_q = c_PROD_W'(w_x_q) * c_PROD_W'(w_g);

    assign w_res_i = vsn_sat_round(64'(w_p_i), SAMPLE_W);
    assign w_res_q = vsn_sat_round(64'(w_p_q), SAMPLE_W);

    // Upper bits of the helper result are sign copies once clipped.
    assign w_unused_hi = ^{w_res_i.val[VSN_RES_W-1:SAMPLE_W],
                           w_res_q.val[VSN_RES_W-1:SAMPLE_W]};

    assign w_load_sat = w_en && r_s1_valid && (w_res_i.sat || w_res_q.sat);

    // Stage 2: load the output slot; data and tlast hold while stalled.
    // A saturation in the loading cycle overrides a simultaneous clear.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_sat      <= 1'b0;
        end else begin
            if (w_en) begin
                r_m_tvalid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_m_tdata <= {w_res_q.val[SAMPLE_W-1:0], w_res_i.val[SAMPLE_W-1:0]};
                    r_m_tlast <= r_s1_last;
                end
            end
            if (w_load_sat) begin
                r_sat <= 1'b1;
            end else if (sat_clr) begin
                r_sat <= 1'b0;
            end
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tlast  = r_m_tlast;
    assign m_tdata  = r_m_tdata;
    assign sat_flag = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_vsn_channel_delay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vsn_channel_delay
//  Description : Self-checking bench for vsn_channel_delay: gain vector
//                table, directed delay/wrap/config sequences and a random
//                backpressured stream against a sample-history model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vsn_channel_delay;
    import vsn_pkg::*;

    localparam int SW = 16;
    localparam int AW = 10;
    localparam int GW = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic [2*SW-1:0] s_tdata;
    logic          s_tvalid, s_tlast, s_tready;
    logic [2*SW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic [AW-1:0] cfg_delay;
    logic [GW-1:0] cfg_gain;
    logic          cfg_load, sat_flag, sat_clr;

    vsn_channel_delay #(.SAMPLE_W(SW), .ADDR_W(AW), .GAIN_W(GW)) dut (
        .aclk(aclk), .areset(areset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .cfg_delay(cfg_delay), .cfg_gain(cfg_gain), .cfg_load(cfg_load),
        .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: history of samples since the last config change;
    // output n is gain * history[n-D], or zero while n < D.
    // ------------------------------------------------------------------
    typedef struct {
        logic [2*SW-1:0] data;
        logic            last;
    } beat_t;

    int      md = 0;
    int      mg = GAIN_ONE;
    vsn_iq_t hist[$];
    beat_t   expq[$];
    int      got_i[$];
    bit      s_fire = 1'b0;

    // floor((x*g + 0.5*2^14) / 2^14), clipped to the signed 16-bit range
    function automatic int scale(input int x, input int g);
        longint num, r;
        num = longint'(x) * longint'(g) + 64'sd8192;
        r   = num / 16384;
        if ((num < 0) && ((num % 16384) != 0)) r = r - 1;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic void model_accept(input logic [2*SW-1:0] d, input logic last);
        vsn_iq_t in_s, x, o;
        beat_t   b;
        int      n;
        in_s = d;
        hist.push_back(in_s);
        n = hist.size() - 1;
        x = (n >= md) ? hist[n - md] : '0;
        o.i = 16'(scale(int'(x.i), mg));
        o.q = 16'(scale(int'(x.q), mg));
        b.data = o;
        b.last = last;
        expq.push_back(b);
    endfunction

    function automatic logic [2*SW-1:0] pack(input int i, input int q);
        return {q[15:0], i[15:0]};
    endfunction

    // Monitor on the falling edge: record input accepts into the model and
    // compare every presented output slot with the model's head entry.
    always @(negedge aclk) begin
        s_fire = 1'b0;
        if (!areset) begin
            if (s_tvalid && s_tready) begin
                s_fire = 1'b1;
                model_accept(s_tdata, s_tlast);
            end
            if (m_tvalid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: got data %h expected no output", m_tdata);
                end else begin
                    check("out_data", longint'(m_tdata), longint'(expq[0].data));
                    check("out_last", longint'(m_tlast), longint'(expq[0].last));
                    if (m_tready) begin
                        got_i.push_back(int'($signed(m_tdata[SW-1:0])));
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1)
    // ------------------------------------------------------------------
    logic [2*SW-1:0] txd[$];
    logic            txl[$];

    task automatic load_cfg(input int d, input int g);
        cfg_delay = AW'(d);
        cfg_gain  = GW'(g);
        cfg_load  = 1'b1;
        @(posedge aclk); #1;
        cfg_load = 1'b0;
        md = d;
        mg = g;
        hist.delete();
    endtask

    task automatic pulse_clr();
        sat_clr = 1'b1;
        @(posedge aclk); #1;
        sat_clr = 1'b0;
    endtask

    task automatic run_stream(input bit gaps, input bit rnd_ready, input int limit);
        int idx = 0;
        int cyc = 0;
        bit pending = 1'b0;
        got_i.delete();
        while (((idx < txd.size()) || (expq.size() != 0) || pending) && (cyc < limit)) begin
            if (pending && s_fire) begin
                idx++;
                pending = 1'b0;
            end
            if (!pending && (idx < txd.size()) && (!gaps || ($urandom_range(0, 99) < 70))) begin
                s_tdata = txd[idx];
                s_tlast = txl[idx];
                pending = 1'b1;
            end
            s_tvalid = pending;
            m_tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(posedge aclk); #1;
            cyc++;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        if (cyc >= limit) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got %0d of %0d inputs after %0d cycles", idx, txd.size(), cyc);
        end
        check("out_count", got_i.size(), txd.size());
    endtask

    // Gain vectors applied with D=0
    typedef struct {
        int g;
        int ii, iq;
        int ei, eq;
        bit es;
    } vec_t;

    vec_t vt[7];

    initial begin
        int ramp_exp[10];
        vt[0] = '{16384,    100,   -100,    100,   -100, 1'b0};
        vt[1] = '{16384,  32767, -32768,  32767, -32768, 1'b0};
        vt[2] = '{-16384, -32768,     5,  32767,     -5, 1'b1};
        vt[3] = '{8192,       3,     -3,      2,     -1, 1'b0};
        vt[4] = '{32767,  20000, -20000,  32767, -32768, 1'b1};
        vt[5] = '{0,      12345,     -1,      0,      0, 1'b0};
        vt[6] = '{-32768,    -1,      1,      2,     -2, 1'b0};
        ramp_exp = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6};

        areset = 1'b1;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        cfg_delay = '0; cfg_gain = '0; cfg_load = 1'b0; sat_clr = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", longint'(m_tdata), 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_sat_flag", sat_flag, 0);
        areset = 1'b0;
        @(posedge aclk); #1;
        check("rst_s_tready", s_tready, 1);

        // Reset config is D=0, unity gain
        txd = {pack(7, -9)};
        txl = {1'b1};
        run_stream(1'b0, 1'b0, 50);
        if (got_i.size() > 0) check("rst_cfg_out", got_i[0], 7);

        // Gain table, two-cycle latency, sticky saturation per vector
        foreach (vt[k]) begin
            load_cfg(0, vt[k].g);
            pulse_clr();
            s_tdata = pack(vt[k].ii, vt[k].iq);
            s_tlast = 1'b1;
            s_tvalid = 1'b1;
            @(posedge aclk); #1;
            s_tvalid = 1'b0;
            check("lat_not_yet", m_tvalid, 0);
            @(posedge aclk); #1;
            check("lat_valid", m_tvalid, 1);
            check("vec_i", longint'($signed(m_tdata[SW-1:0])), vt[k].ei);
            check("vec_q", longint'($signed(m_tdata[2*SW-1:SW])), vt[k].eq);
            check("vec_sat", sat_flag, vt[k].es);
            @(posedge aclk); #1;
        end

        // Saturation set beats a coincident clear; a later clear drops it
        load_cfg(0, -16384);
        pulse_clr();
        check("sat_cleared", sat_flag, 0);
        s_tdata = pack(-32768, 0);
        s_tvalid = 1'b1;
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        sat_clr = 1'b1;
        @(posedge aclk); #1;
        sat_clr = 1'b0;
        check("sat_set_wins", sat_flag, 1);
        check("sat_out_i", longint'($signed(m_tdata[SW-1:0])), 32767);
        @(posedge aclk); #1;
        pulse_clr();
        check("sat_clr", sat_flag, 0);

        // D=4 ramp
        load_cfg(4, GAIN_ONE);
        txd.delete(); txl.delete();
        for (int k = 1; k <= 10; k++) begin
            txd.push_back(pack(k, 0));
            txl.push_back(k == 10);
        end
        run_stream(1'b0, 1'b0, 100);
        for (int k = 0; k < 10; k++) begin
            if (k < got_i.size()) check("ramp_d4", got_i[k], ramp_exp[k]);
        end

        // D=1023 across a pointer wrap
        load_cfg(1023, GAIN_ONE);
        txd.delete(); txl.delete();
        for (int k = 0; k < 2048; k++) begin
            txd.push_back(pack(k + 1, -k));
            txl.push_back((k % 256) == 255);
        end
        run_stream(1'b0, 1'b0, 5000);
        if (got_i.size() == 2048) begin
            check("wrap_last_zero", got_i[1022], 0);
            check("wrap_first", got_i[1023], 1);
            check("wrap_end", got_i[2047], 1025);
        end

        // cfg_load coinciding with an accept: that sample is history slot 0
        md = 2; mg = GAIN_ONE; hist.delete(); got_i.delete();
        cfg_delay = AW'(2); cfg_gain = GW'(GAIN_ONE); cfg_load = 1'b1;
        s_tdata = pack(11, 0); s_tlast = 1'b0; s_tvalid = 1'b1;
        @(posedge aclk); #1;
        cfg_load = 1'b0;
        s_tdata = pack(12, 0);
        @(posedge aclk); #1;
        s_tdata = pack(13, 0); s_tlast = 1'b1;
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        check("load_accept_cnt", got_i.size(), 3);
        if (got_i.size() == 3) begin
            check("load_accept_0", got_i[0], 0);
            check("load_accept_2", got_i[2], 11);
        end

        // Random stream, D=7, random gain, gaps and backpressure
        load_cfg(7, int'($urandom_range(0, 40000)) - 20000);
        txd.delete(); txl.delete();
        for (int k = 0; k < 300; k++) begin
            txd.push_back($urandom());
            txl.push_back($urandom_range(0, 3) == 0);
        end
        run_stream(1'b1, 1'b1, 5000);

        // Asynchronous reset while an output is stalled
        load_cfg(0, GAIN_ONE);
        m_tready = 1'b0;
        s_tdata = pack(55, 66);
        s_tvalid = 1'b1;
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("stall_valid", m_tvalid, 1);
        check("stall_s_tready", s_tready, 0);
        #2;
        areset = 1'b1;
        #1;
        check("async_rst_valid", m_tvalid, 0);
        check("async_rst_data", longint'(m_tdata), 0);
        expq.delete(); hist.delete();
        md = 0; mg = GAIN_ONE;
        m_tready = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;
        txd = {pack(-3, 4)};
        txl = {1'b0};
        run_stream(1'b0, 1'b0, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
